// File: rtl/mux_rr_arbiter_if.sv
// Requester/downstream bundle for mux_rr_arbiter; the lock vector exists only when
// MUX_RR_ARBITER_LOCK_EN is defined.
interface mux_rr_arbiter_if #(
  parameter int N = 9,
  parameter int W = 16
);
  logic [N-1:0]   req;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   ack;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [3:0]     sel;
`ifdef MUX_RR_ARBITER_LOCK_EN
  logic [N-1:0]   lock;

  modport master (output req, in_data, out_ready, lock,
                  input  ack, out_valid, out_data, sel);
  modport slave  (input  req, in_data, out_ready, lock,
                  output ack, out_valid, out_data, sel);
`else
  modport master (output req, in_data, out_ready,
                  input  ack, out_valid, out_data, sel);
  modport slave  (input  req, in_data, out_ready,
                  output ack, out_valid, out_data, sel);
`endif
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter feeding a registered N:1 data mux, one beat per cycle under load.
// Optional lock feature (extra LOCK state, lock port) enabled by MUX_RR_ARBITER_LOCK_EN.
module mux_rr_arbiter #(
  parameter int N = 9,
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1
`ifdef MUX_RR_ARBITER_LOCK_EN
    ,
    LOCK = 2'd2
`endif
  } stateType;

  stateType     stateReg, stateNext;
  logic [3:0]   selReg, selNext, selInc;
  logic [3:0]   ptrReg, ptrNext;
  logic [W-1:0] outData, dataNext;
  logic [N-1:0] ackVec;
  logic [4:0]   hit;
  logic         accept, load;

  // Returns {found, index} of the first set bit of vec searching start, start+1, ... wrapping at N.
  function automatic logic [4:0] pick(input logic [N-1:0] vec, input logic [3:0] start);
    logic [N-1:0] rot;
    logic [4:0]   res;
    logic [4:0]   sum;
    rot = N'({vec, vec} >> start);
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) res = {1'b1, 4'(k)};
    end
    sum = {1'b0, res[3:0]} + {1'b0, start};
    if (sum >= 5'(N)) sum = sum - 5'(N);
    if (res[4]) res = {1'b1, sum[3:0]};
    return res;
  endfunction

  always_comb begin
    stateNext = stateReg;
    selNext   = selReg;
    ptrNext   = ptrReg;
    load      = 1'b0;
    hit       = '0;
    ackVec    = '0;
    accept    = (stateReg == BUSY) && bus.out_ready;
    selInc    = (selReg == 4'(N - 1)) ? 4'd0 : selReg + 4'd1;
    if (accept) ackVec[selReg] = 1'b1;

    case (stateReg)
      IDLE: begin
        hit = pick(bus.req, ptrReg);
        if (hit[4]) begin
          selNext   = hit[3:0];
          load      = 1'b1;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
`ifdef MUX_RR_ARBITER_LOCK_EN
          if (bus.lock[selReg]) stateNext = LOCK;
          else
`endif
          begin
            // The accepted requester is masked so it cannot win again on the same edge.
            ptrNext = selInc;
            hit     = pick(bus.req & ~ackVec, selInc);
            if (hit[4]) begin
              selNext = hit[3:0];
              load    = 1'b1;
            end else begin
              stateNext = IDLE;
            end
          end
        end
      end
`ifdef MUX_RR_ARBITER_LOCK_EN
      LOCK: begin
        if (bus.req[selReg]) begin
          load      = 1'b1;
          stateNext = BUSY;
        end
      end
`endif
      default: stateNext = IDLE;
    endcase

    dataNext = '0;
    for (int i = 0; i < N; i++) begin
      if (selNext == 4'(i)) dataNext = bus.in_data[i*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      selReg   <= '0;
      ptrReg   <= '0;
      outData  <= '0;
    end else begin
      stateReg <= stateNext;
      selReg   <= selNext;
      ptrReg   <= ptrNext;
      if (load) outData <= dataNext;
    end
  end

  assign bus.ack       = ackVec;
  assign bus.out_valid = (stateReg == BUSY);
  assign bus.out_data  = outData;
  assign bus.sel       = selReg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter with hand-computed grant sequences;
// the lock scenario runs only when MUX_RR_ARBITER_LOCK_EN is defined.
module tb_mux_rr_arbiter;

  localparam int N = 9;
  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;

  mux_rr_arbiter_if #(.N(N), .W(W)) bus ();

  mux_rr_arbiter #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] reqVal, input logic readyVal);
    bus.req       = reqVal;
    bus.out_ready = readyVal;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b0;
    applyStimulus('0, 1'b0);
    // Slice i carries i, except slice 8 carries 9 so the last requester is distinguishable.
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = (i == 8) ? 16'd9 : 16'(i);
`ifdef MUX_RR_ARBITER_LOCK_EN
    bus.lock = '0;
`endif

    nextCycle();
    nextCycle();
    checkOutput("rst_valid", 32'(bus.out_valid), 0);
    checkOutput("rst_sel",   32'(bus.sel),       0);
    checkOutput("rst_data",  32'(bus.out_data),  0);
    checkOutput("rst_ack",   32'(bus.ack),       0);
    #3 rst_n = 1'b1;

    for (int c = 0; c < 5; c++) begin
      nextCycle();
      checkOutput("idle_valid", 32'(bus.out_valid), 0);
      checkOutput("idle_sel",   32'(bus.sel),       0);
      checkOutput("idle_data",  32'(bus.out_data),  0);
    end

    // All requesters busy: grants must cycle 0..8 with one ack per cycle.
    applyStimulus(9'h1FF, 1'b1);
    for (int c = 0; c < 20; c++) begin
      int s;
      s = c % 9;
      nextCycle();
      checkOutput("rr_valid", 32'(bus.out_valid), 1);
      checkOutput("rr_sel",   32'(bus.sel),       s);
      checkOutput("rr_data",  32'(bus.out_data),  (s == 8) ? 9 : s);
      checkOutput("rr_ack",   32'(bus.ack),       1 << s);
    end
    applyStimulus('0, 1'b1);
    nextCycle();
    checkOutput("drain_valid", 32'(bus.out_valid), 0);

    // Single requester stalled by downstream, then accepted once.
    applyStimulus(9'h010, 1'b0);
    for (int c = 0; c < 4; c++) begin
      nextCycle();
      checkOutput("hold_valid", 32'(bus.out_valid), 1);
      checkOutput("hold_sel",   32'(bus.sel),       4);
      checkOutput("hold_data",  32'(bus.out_data),  4);
      checkOutput("hold_ack",   32'(bus.ack),       0);
    end
    applyStimulus(9'h010, 1'b1);
    #1;
    checkOutput("single_ack", 32'(bus.ack), 32'h010);
    applyStimulus('0, 1'b1);
    nextCycle();
    checkOutput("single_idle",  32'(bus.out_valid), 0);
    checkOutput("single_ack0",  32'(bus.ack),       0);
    nextCycle();
    checkOutput("single_noack", 32'(bus.ack),       0);

    // Pointer wrap: after requester 8 is accepted the search restarts at 0.
    applyStimulus(9'h100, 1'b1);
    nextCycle();
    checkOutput("wrap_sel8",  32'(bus.sel),      8);
    checkOutput("wrap_data8", 32'(bus.out_data), 9);
    checkOutput("wrap_ack8",  32'(bus.ack),      32'h100);
    applyStimulus('0, 1'b1);
    nextCycle();
    checkOutput("wrap_idle", 32'(bus.out_valid), 0);
    applyStimulus(9'h101, 1'b1);
    nextCycle();
    checkOutput("wrap_sel0",  32'(bus.sel),      0);
    checkOutput("wrap_data0", 32'(bus.out_data), 0);
    applyStimulus('0, 1'b1);
    nextCycle();
    checkOutput("wrap_done", 32'(bus.out_valid), 0);

    // Short asynchronous reset pulse while holding a beat for requester 5.
    applyStimulus(9'h020, 1'b0);
    nextCycle();
    checkOutput("mr_busy_sel",   32'(bus.sel),       5);
    checkOutput("mr_busy_valid", 32'(bus.out_valid), 1);
    applyStimulus(9'h060, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mr_valid", 32'(bus.out_valid), 0);
    checkOutput("mr_ack",   32'(bus.ack),       0);
    checkOutput("mr_sel",   32'(bus.sel),       0);
    checkOutput("mr_data",  32'(bus.out_data),  0);
    #2 rst_n = 1'b1;
    nextCycle();
    checkOutput("mr_grant_valid", 32'(bus.out_valid), 1);
    checkOutput("mr_grant_sel",   32'(bus.sel),       5);
    checkOutput("mr_grant_data",  32'(bus.out_data),  5);
    applyStimulus('0, 1'b1);
    nextCycle();
    checkOutput("mr_done", 32'(bus.out_valid), 0);

`ifdef MUX_RR_ARBITER_LOCK_EN
    // Requester 2 locks the mux for three beats, then releases it to requester 3.
    bus.lock = 9'h004;
    applyStimulus(9'h00C, 1'b1);
    for (int b = 0; b < 3; b++) begin
      logic got;
      got = 1'b0;
      for (int c = 0; c < 4 && !got; c++) begin
        nextCycle();
        if (bus.out_valid) got = 1'b1;
      end
      checkOutput("lock_seen", 32'(got),     1);
      checkOutput("lock_sel",  32'(bus.sel), 2);
    end
    bus.lock = '0;
    nextCycle();
    checkOutput("lock_next_valid", 32'(bus.out_valid), 1);
    checkOutput("lock_next_sel",   32'(bus.sel),       3);
    applyStimulus('0, 1'b1);
    nextCycle();
    checkOutput("lock_done", 32'(bus.out_valid), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
